syn_gpu_poly_lb_mstr: RTL and testbench

Local-bus initiator that programs and launches the GPU polygon drawer. It accepts one polygon job descriptor at a time (vertex list plus colour) and serialises it into register writes on the local bus. It then writes the start bit and polls the drawer's status register until the drawer reports idle. It sits between the GPU job dispatcher and the polygon drawer's local-bus slave port, and is the initiating end of that protocol.

---
 rtl/syn_gpu_poly_lb_mstr.sv | 226 ++++++++++++++++++++++
 tb/tb_syn_gpu_poly_lb_mstr.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/syn_gpu_poly_lb_mstr.sv
// Local-bus initiator for the polygon drawer: serialises one job descriptor into
// register writes, kicks the drawer, then polls STATUS until it reports idle.
module syn_gpu_poly_lb_mstr #(
    parameter int unsigned               LB_ADDR_W = 8,
    parameter int unsigned               LB_DATA_W = 32,
    parameter logic [LB_ADDR_W-1:0]      BASE_ADDR = 8'h40,
    parameter int unsigned               X_W       = 10,
    parameter int unsigned               Y_W       = 9,
    parameter int unsigned               MAX_VERTS = 4,
    parameter int unsigned               POLL_GAP  = 4,
    parameter int unsigned               TIMEOUT   = 64
) (
    input  logic                       clk_ir,
    input  logic                       rst_sync_l,
    input  logic                       job_valid,
    output logic                       job_ready,
    input  logic [2:0]                 job_nverts,
    input  logic [7:0]                 job_color,
    input  logic [MAX_VERTS*X_W-1:0]   job_vx,
    input  logic [MAX_VERTS*Y_W-1:0]   job_vy,
    output logic                       job_done,
    output logic                       job_err,
    output logic                       lb_wr_en,
    output logic                       lb_rd_en,
    output logic [LB_ADDR_W-1:0]       lb_addr,
    output logic [LB_DATA_W-1:0]       lb_wr_data,
    input  logic                       lb_wr_valid,
    input  logic                       lb_rd_valid,
    input  logic [LB_DATA_W-1:0]       lb_rd_data
);

    localparam int unsigned IDX_W   = $clog2(2 * MAX_VERTS + 2);
    localparam int unsigned CNT_MAX = (TIMEOUT > POLL_GAP) ? TIMEOUT : POLL_GAP;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [3:0] {
        StIdle, StWr, StWrWait, StKick, StKickWait, StPollGap, StPoll, StPollWait, StDone
    } state_e;

    state_e                   state_q, state_d;
    logic [IDX_W-1:0]         idx_q, idx_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic                     err_q, err_d;
    logic                     ready_q, ready_d;
    logic                     load;
    logic [2:0]               nverts_q;
    logic [7:0]               color_q;
    logic [MAX_VERTS*X_W-1:0] vx_q;
    logic [MAX_VERTS*Y_W-1:0] vy_q;
    logic [IDX_W-1:0]         last_idx;
    logic                     expired;
    logic                     bad_job;
    logic [IDX_W-1:0]         vert_sel;
    logic [X_W-1:0]           vx_sel;
    logic [Y_W-1:0]           vy_sel;
    logic [LB_DATA_W-1:0]     wr_word;
    logic                     unused_rd;

    assign unused_rd = ^lb_rd_data[LB_DATA_W-1:1];
    // Write index k targets offset 2+k: NVERTS, COLOR, then X/Y pairs.
    assign last_idx  = IDX_W'({nverts_q, 1'b1});
    assign expired   = (cnt_q == CNT_W'(TIMEOUT - 1));
    assign bad_job   = (job_nverts < 3'd3) || (32'(job_nverts) > MAX_VERTS);

    always_ff @(posedge clk_ir) begin
        if (!rst_sync_l) begin
            state_q  <= StIdle;
            idx_q    <= '0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
            ready_q  <= 1'b0;
            nverts_q <= '0;
            color_q  <= '0;
            vx_q     <= '0;
            vy_q     <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            ready_q <= ready_d;
            if (load) begin
                nverts_q <= job_nverts;
                color_q  <= job_color;
                vx_q     <= job_vx;
                vy_q     <= job_vy;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        err_d   = 1'b0;
        load    = 1'b0;
        case (state_q)
            StIdle: begin
                if (job_valid && ready_q) begin
                    load = 1'b1;
                    if (bad_job) begin
                        err_d = 1'b1;
                    end else begin
                        state_d = StWr;
                        idx_d   = '0;
                    end
                end
            end
            // The counter holds cycles elapsed since the strobe, so the first wait cycle sees 1.
            StWr: begin
                state_d = StWrWait;
                cnt_d   = CNT_W'(1);
            end
            StWrWait: begin
                if (lb_wr_valid) begin
                    if (idx_q == last_idx) begin
                        state_d = StKick;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = StWr;
                    end
                end else if (expired) begin
                    err_d   = 1'b1;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StKick: begin
                state_d = StKickWait;
                cnt_d   = CNT_W'(1);
            end
            StKickWait: begin
                if (lb_wr_valid) begin
                    state_d = StPollGap;
                    cnt_d   = '0;
                end else if (expired) begin
                    err_d   = 1'b1;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StPollGap: begin
                if (cnt_q == CNT_W'(POLL_GAP - 1)) begin
                    state_d = StPoll;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StPoll: begin
                state_d = StPollWait;
                cnt_d   = CNT_W'(1);
            end
            StPollWait: begin
                if (lb_rd_valid) begin
                    if (lb_rd_data[0]) begin
                        state_d = StPollGap;
                        cnt_d   = '0;
                    end else begin
                        state_d = StDone;
                    end
                end else if (expired) begin
                    err_d   = 1'b1;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
        // Ready is withheld for the cycle carrying the error pulse.
        ready_d = (state_d == StIdle) && !err_d;
    end

    always_comb begin
        vert_sel = idx_q - IDX_W'(2);
        vx_sel   = '0;
        vy_sel   = '0;
        for (int i = 0; i < MAX_VERTS; i++) begin
            if (vert_sel[IDX_W-1:1] == (IDX_W-1)'(i)) begin
                vx_sel = vx_q[i*X_W +: X_W];
                vy_sel = vy_q[i*Y_W +: Y_W];
            end
        end
        if (idx_q == '0) begin
            wr_word = LB_DATA_W'(nverts_q);
        end else if (idx_q == IDX_W'(1)) begin
            wr_word = LB_DATA_W'(color_q);
        end else if (vert_sel[0]) begin
            wr_word = LB_DATA_W'(vy_sel);
        end else begin
            wr_word = LB_DATA_W'(vx_sel);
        end
    end

    always_comb begin
        lb_wr_en   = 1'b0;
        lb_rd_en   = 1'b0;
        lb_addr    = '0;
        lb_wr_data = '0;
        case (state_q)
            StWr: begin
                lb_wr_en   = 1'b1;
                lb_addr    = BASE_ADDR + LB_ADDR_W'(idx_q) + LB_ADDR_W'(2);
                lb_wr_data = wr_word;
            end
            StKick: begin
                lb_wr_en   = 1'b1;
                lb_addr    = BASE_ADDR;
                lb_wr_data = LB_DATA_W'(1);
            end
            StPoll: begin
                lb_rd_en = 1'b1;
                lb_addr  = BASE_ADDR + LB_ADDR_W'(1);
            end
            default: ;
        endcase
    end

    assign job_ready = ready_q;
    assign job_err   = err_q;
    assign job_done  = (state_q == StDone);

endmodule

// File: tb/tb_syn_gpu_poly_lb_mstr.sv
// Directed bench for syn_gpu_poly_lb_mstr: cycle-accurate slave model, job vector
// table and hand-written reset / sequencing cases.
module tb_syn_gpu_poly_lb_mstr;

    localparam int unsigned MAXV = 4;
    localparam int unsigned XW   = 10;
    localparam int unsigned YW   = 9;
    localparam int unsigned PG   = 4;
    localparam int unsigned TO   = 64;

    logic                 clk = 1'b0;
    logic                 rst_sync_l;
    logic                 job_valid;
    logic                 job_ready;
    logic [2:0]           job_nverts;
    logic [7:0]           job_color;
    logic [MAXV*XW-1:0]   job_vx;
    logic [MAXV*YW-1:0]   job_vy;
    logic                 job_done;
    logic                 job_err;
    logic                 lb_wr_en;
    logic                 lb_rd_en;
    logic [7:0]           lb_addr;
    logic [31:0]          lb_wr_data;
    logic                 lb_wr_valid;
    logic                 lb_rd_valid;
    logic [31:0]          lb_rd_data;

    always #5 clk = ~clk;

    syn_gpu_poly_lb_mstr #(
        .LB_ADDR_W (8),
        .LB_DATA_W (32),
        .BASE_ADDR (8'h40),
        .X_W       (XW),
        .Y_W       (YW),
        .MAX_VERTS (MAXV),
        .POLL_GAP  (PG),
        .TIMEOUT   (TO)
    ) dut (
        .clk_ir      (clk),
        .rst_sync_l  (rst_sync_l),
        .job_valid   (job_valid),
        .job_ready   (job_ready),
        .job_nverts  (job_nverts),
        .job_color   (job_color),
        .job_vx      (job_vx),
        .job_vy      (job_vy),
        .job_done    (job_done),
        .job_err     (job_err),
        .lb_wr_en    (lb_wr_en),
        .lb_rd_en    (lb_rd_en),
        .lb_addr     (lb_addr),
        .lb_wr_data  (lb_wr_data),
        .lb_wr_valid (lb_wr_valid),
        .lb_rd_valid (lb_rd_valid),
        .lb_rd_data  (lb_rd_data)
    );

    typedef struct {
        int          cyc;
        bit          wr;
        logic [7:0]  addr;
        logic [31:0] data;
    } txn_t;

    typedef struct {
        logic [2:0] n;
        int         slow_wr;
        int         slow_lat;
        int         rd_lat;
        int         busy;
        int         exp_done;
        int         exp_err;
        int         exp_pulse;
        int         exp_wr;
        int         exp_rd;
    } vec_t;

    txn_t log_q[$];
    vec_t vecs[9];

    int tests = 0, fails = 0, cyc = 0, t0 = 0;
    int slow_wr = -1, slow_lat = 1, rd_lat = 1, busy_reads = 0;
    int wr_num = 0, rd_num = 0, wr_cd = 0, rd_cd = 0;
    int done_n = 0, err_n = 0, pulse_cyc = -1, both_n = 0, idle_bad = 0;
    int nwr, nrd, nlog_pulse;
    logic ready_at_pulse, ready_after;

    // (10,20),(100,20),(50,150) plus a 4th vertex (300,200) used only by n=4 jobs
    logic [MAXV*XW-1:0] vx_base = {10'd300, 10'd50, 10'd100, 10'd10};
    logic [MAXV*YW-1:0] vy_base = {9'd200, 9'd150, 9'd20, 9'd20};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One cycle: outputs are sampled 1 time unit after the edge, slave inputs driven then.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        lb_wr_valid = 1'b0;
        lb_rd_valid = 1'b0;
        lb_rd_data  = '0;
        if (wr_cd > 0) begin
            wr_cd--;
            if (wr_cd == 0) lb_wr_valid = 1'b1;
        end
        if (rd_cd > 0) begin
            rd_cd--;
            if (rd_cd == 0) begin
                lb_rd_valid = 1'b1;
                lb_rd_data  = (rd_num <= busy_reads) ? 32'h1 : 32'h0;
            end
        end
        if (lb_wr_en) begin
            log_q.push_back('{cyc - t0, 1'b1, lb_addr, lb_wr_data});
            wr_cd = (wr_num == slow_wr) ? slow_lat : 1;
            wr_num++;
        end
        if (lb_rd_en) begin
            log_q.push_back('{cyc - t0, 1'b0, lb_addr, lb_wr_data});
            rd_num++;
            rd_cd = rd_lat;
        end
        if (lb_wr_en && lb_rd_en) both_n++;
        if (!lb_wr_en && !lb_rd_en && (lb_addr != 8'h0 || lb_wr_data != 32'h0)) idle_bad++;
        if (job_done) begin done_n++; pulse_cyc = cyc - t0; end
        if (job_err)  begin err_n++;  pulse_cyc = cyc - t0; end
    endtask

    task automatic start_job(input logic [2:0] n);
        log_q.delete();
        done_n = 0; err_n = 0; pulse_cyc = -1;
        wr_num = 0; rd_num = 0; wr_cd = 0; rd_cd = 0;
        job_nverts = n;
        job_color  = 8'h5A;
        job_vx     = vx_base;
        job_vy     = vy_base;
        job_valid  = 1'b1;
        for (int k = 0; k < 20 && !job_ready; k++) tick();
        check("accept_ready", job_ready, 1'b1);
        t0 = cyc;
        tick();
        job_valid = 1'b0;
        check("ready_low_after_accept", job_ready, 1'b0);
    endtask

    task automatic run_job(input logic [2:0] n, input int max_cyc);
        start_job(n);
        for (int k = 0; k < max_cyc && (done_n + err_n) == 0; k++) tick();
        ready_at_pulse = job_ready;
        nlog_pulse     = log_q.size();
        tick();
        ready_after = job_ready;
        repeat (4) tick();
        nwr = 0;
        nrd = 0;
        foreach (log_q[j]) begin
            if (log_q[j].wr) nwr++;
            else             nrd++;
        end
    endtask

    initial begin
        logic [7:0]  exp_addr [9];
        logic [31:0] exp_data [9];
        int          rd_seen;

        //           n     swr slat rlat busy done err pulse wr rd
        vecs[0] = '{3'd3, -1, 1,   1,   0,   1,   0,  25,   9, 1};
        vecs[1] = '{3'd3, -1, 1,   1,   3,   1,   0,  43,   9, 4};
        vecs[2] = '{3'd2, -1, 1,   1,   0,   0,   1,  1,    0, 0};
        vecs[3] = '{3'd5, -1, 1,   1,   0,   0,   1,  1,    0, 0};
        vecs[4] = '{3'd3, 2,  66,  1,   0,   0,   1,  69,   3, 0};
        vecs[5] = '{3'd3, 2,  63,  1,   0,   1,   0,  87,   9, 1};
        vecs[6] = '{3'd4, -1, 1,   1,   0,   1,   0,  29,  11, 1};
        vecs[7] = '{3'd3, -1, 1,   3,   0,   1,   0,  27,   9, 1};
        vecs[8] = '{3'd3, 8,  70,  1,   0,   0,   1,  81,   9, 0};

        rst_sync_l  = 1'b0;
        job_valid   = 1'b0;
        job_nverts  = '0;
        job_color   = '0;
        job_vx      = '0;
        job_vy      = '0;
        lb_wr_valid = 1'b0;
        lb_rd_valid = 1'b0;
        lb_rd_data  = '0;

        repeat (3) tick();
        check("reset_ready", job_ready, 1'b0);
        check("reset_outputs", {job_done, job_err, lb_wr_en, lb_rd_en, lb_addr, lb_wr_data}, '0);
        rst_sync_l = 1'b1;
        tick();
        check("ready_after_release", job_ready, 1'b1);

        for (int i = 0; i < 9; i++) begin
            slow_wr    = vecs[i].slow_wr;
            slow_lat   = vecs[i].slow_lat;
            rd_lat     = vecs[i].rd_lat;
            busy_reads = vecs[i].busy;
            run_job(vecs[i].n, 200);
            check($sformatf("v%0d_done_count", i), done_n, vecs[i].exp_done);
            check($sformatf("v%0d_err_count", i), err_n, vecs[i].exp_err);
            check($sformatf("v%0d_pulse_cycle", i), pulse_cyc, vecs[i].exp_pulse);
            check($sformatf("v%0d_writes", i), nwr, vecs[i].exp_wr);
            check($sformatf("v%0d_reads", i), nrd, vecs[i].exp_rd);
            check($sformatf("v%0d_ready_in_pulse", i), ready_at_pulse, 1'b0);
            check($sformatf("v%0d_ready_after", i), ready_after, 1'b1);
            check($sformatf("v%0d_no_late_traffic", i), log_q.size(), nlog_pulse);
        end

        // Base job: exact addresses, data and strobe cycles.
        exp_addr = '{8'h42, 8'h43, 8'h44, 8'h45, 8'h46, 8'h47, 8'h48, 8'h49, 8'h40};
        exp_data = '{32'd3, 32'h5A, 32'd10, 32'd20, 32'd100, 32'd20, 32'd50, 32'd150, 32'd1};
        slow_wr = -1; slow_lat = 1; rd_lat = 1; busy_reads = 0;
        run_job(3'd3, 200);
        check("base_log_size", log_q.size(), 10);
        if (log_q.size() == 10) begin
            for (int k = 0; k < 9; k++) begin
                check($sformatf("base_w%0d_addr", k), log_q[k].addr, exp_addr[k]);
                check($sformatf("base_w%0d_data", k), log_q[k].data, exp_data[k]);
                check($sformatf("base_w%0d_cyc", k), log_q[k].cyc, 1 + 2 * k);
            end
            check("base_rd_is_read", log_q[9].wr, 1'b0);
            check("base_rd_addr", log_q[9].addr, 8'h41);
            check("base_rd_cyc", log_q[9].cyc, 19 + PG);
        end
        check("base_done_cyc", pulse_cyc, 19 + PG + 2);

        // Busy for three reads: read strobes spaced by the wait cycle plus POLL_GAP.
        busy_reads = 3;
        run_job(3'd3, 200);
        rd_seen = 0;
        foreach (log_q[j]) begin
            if (!log_q[j].wr) begin
                check($sformatf("busy_rd%0d_cyc", rd_seen), log_q[j].cyc, 23 + rd_seen * (PG + 2));
                rd_seen++;
            end
        end
        check("busy_rd_total", rd_seen, 4);
        busy_reads = 0;

        // Reset while a STATUS read is outstanding.
        rd_lat = 10;
        start_job(3'd3);
        for (int k = 0; k < 60 && !lb_rd_en; k++) tick();
        check("pre_reset_read_strobe", lb_rd_en, 1'b1);
        tick();
        rst_sync_l = 1'b0;
        tick();
        check("midjob_reset_outputs",
              {job_ready, job_done, job_err, lb_wr_en, lb_rd_en, lb_addr, lb_wr_data}, '0);
        rst_sync_l = 1'b1;
        wr_cd = 0;
        rd_cd = 0;
        tick();
        check("midjob_ready_after_release", job_ready, 1'b1);
        repeat (3) tick();
        check("midjob_no_pulse", done_n + err_n, 0);
        rd_lat = 1;
        run_job(3'd3, 200);
        check("post_reset_done_count", done_n, 1);
        check("post_reset_done_cyc", pulse_cyc, 25);

        check("no_overlap", both_n, 0);
        check("idle_bus_zero", idle_bad, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
